irq_daisy_ctrl: RTL and testbench

//  Parametrised interrupt controller for the single-cycle RISC-V core; replaces the

---
 rtl/irq_pkg.sv | 16 +
 rtl/irq_priority_chain.sv | 34 +++
 rtl/irq_daisy_ctrl.sv | 77 +++++++
 tb/tb_irq_daisy_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants and cause helper for the daisy-chain interrupt controller.
package irq_pkg;

    localparam logic [31:0] IRQ_CAUSE_FLAG    = 32'h8000_0000;
    localparam logic [31:0] EXC_ILLEGAL_CAUSE = 32'd2;
    localparam int          IRQ_MAX_LINES     = 31;
    localparam int          IRQ_IDX_W         = 5;

    typedef logic [31:0]          cause_t;
    typedef logic [IRQ_IDX_W-1:0] irq_idx_t;

    function automatic cause_t irq_cause(input cause_t base, input irq_idx_t idx);
        return IRQ_CAUSE_FLAG | (base + cause_t'(idx));
    endfunction

endpackage

// File: rtl/irq_priority_chain.sv
// Combinational fixed-priority daisy chain; line 0 wins, ready ripples upward.
module irq_priority_chain
    import irq_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0] eligible,
    output logic [N-1:0] grant,
    output irq_idx_t     idx,
    output logic         idle
);

    logic [N:0] ready;

    assign ready[0] = 1'b1;

    generate
        for (genvar k = 0; k < N; k++) begin : g_cell
            assign grant[k]   = eligible[k] & ready[k];
            assign ready[k+1] = ready[k] & ~eligible[k];
        end
    endgenerate

    // Ready surviving the whole chain means nothing is eligible.
    assign idle = ready[N];

    always_comb begin
        idx = '0;
        for (int k = 0; k < N; k++) begin
            if (grant[k]) idx = idx | irq_idx_t'(k);
        end
    end

endmodule

// File: rtl/irq_daisy_ctrl.sv
// Parametrised daisy-chain interrupt controller with edge/level lines.
module irq_daisy_ctrl
    import irq_pkg::*;
#(
    parameter int               N_IRQ      = 16,
    parameter logic [N_IRQ-1:0] EDGE_MASK  = '0,
    parameter logic [31:0]      CAUSE_BASE = 32'd16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             exception_i,
    input  logic [N_IRQ-1:0] irq_req_i,
    input  logic [N_IRQ-1:0] mie_i,
    input  logic             mret_i,
    output logic             irq_o,
    output logic [31:0]      irq_cause_o,
    output logic [N_IRQ-1:0] irq_ret_o
);

    logic [N_IRQ-1:0] req_q;
    logic [N_IRQ-1:0] edge_pend;
    logic [N_IRQ-1:0] served;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] grant;
    logic [N_IRQ-1:0] edge_set;
    logic [N_IRQ-1:0] take_mask;
    logic             busy;
    logic             idle;
    logic             ret_ok;
    irq_idx_t         idx;

    initial begin
        if (N_IRQ < 1 || N_IRQ > IRQ_MAX_LINES) $fatal(1, "N_IRQ out of range");
    end

    assign edge_set = irq_req_i & ~req_q & EDGE_MASK;
    assign pending  = (edge_pend & EDGE_MASK) | (irq_req_i & ~EDGE_MASK);
    assign eligible = pending & mie_i;

    irq_priority_chain #(
        .N (N_IRQ)
    ) u_chain (
        .eligible (eligible),
        .grant    (grant),
        .idx      (idx),
        .idle     (idle)
    );

    // Outputs are forced low while reset is held, not just after it.
    assign irq_o       = ~rst_i & ~busy & ~exception_i & ~idle;
    assign irq_cause_o = irq_o ? irq_cause(CAUSE_BASE, idx) : 32'h0;
    assign take_mask   = irq_o ? grant : '0;
    assign ret_ok      = mret_i & busy & ~exception_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q     <= '0;
            edge_pend <= '0;
            served    <= '0;
            busy      <= 1'b0;
            irq_ret_o <= '0;
        end else begin
            req_q     <= irq_req_i;
            // A fresh edge on the line being taken must not be lost.
            edge_pend <= ((edge_pend & ~take_mask) | edge_set) & EDGE_MASK;
            irq_ret_o <= ret_ok ? served : '0;
            if (irq_o) begin
                busy   <= 1'b1;
                served <= grant;
            end else if (ret_ok) begin
                busy   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_irq_daisy_ctrl.sv
// Directed bench for irq_daisy_ctrl: 16-line edge/level build plus 1- and 31-line builds.
module tb_irq_daisy_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exc = 1'b0;
    logic        mret = 1'b0;
    logic [15:0] req = '0;
    logic [15:0] mie = 16'hFFFF;
    logic        irq;
    logic [31:0] cause;
    logic [15:0] ret;

    logic        req1 = 1'b0;
    logic        mie1 = 1'b1;
    logic        irq1;
    logic [31:0] cause1;
    logic        ret1;

    logic [30:0] req31 = '0;
    logic [30:0] mie31 = '1;
    logic        irq31;
    logic [31:0] cause31;
    logic [30:0] ret31;

    int checks = 0;
    int errors = 0;

    irq_daisy_ctrl #(.N_IRQ(16), .EDGE_MASK(16'h0001), .CAUSE_BASE(32'd16)) dut (
        .clk_i(clk), .rst_i(rst), .exception_i(exc), .irq_req_i(req),
        .mie_i(mie), .mret_i(mret), .irq_o(irq), .irq_cause_o(cause), .irq_ret_o(ret)
    );

    irq_daisy_ctrl #(.N_IRQ(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .exception_i(exc), .irq_req_i(req1),
        .mie_i(mie1), .mret_i(mret), .irq_o(irq1), .irq_cause_o(cause1), .irq_ret_o(ret1)
    );

    irq_daisy_ctrl #(.N_IRQ(31)) dut31 (
        .clk_i(clk), .rst_i(rst), .exception_i(exc), .irq_req_i(req31),
        .mie_i(mie31), .mret_i(mret), .irq_o(irq31), .irq_cause_o(cause31), .irq_ret_o(ret31)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #1;
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_cause", 64'(cause), 64'd0);
        chk("rst_ret", 64'(ret), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_irq", 64'(irq), 64'd0);

        // Small and large builds
        req1 = 1'b1;
        req31 = 31'h4000_0000;
        #1;
        chk("n1_irq", 64'(irq1), 64'd1);
        chk("n1_cause", 64'(cause1), 64'h8000_0010);
        chk("n31_irq", 64'(irq31), 64'd1);
        chk("n31_cause", 64'(cause31), 64'h8000_002E);
        tick();
        req1 = 1'b0;
        req31 = '0;
        mret = 1'b1;
        tick();
        mret = 1'b0;
        chk("n1_ret", 64'(ret1), 64'd1);
        chk("n31_ret", 64'(ret31), 64'h4000_0000);
        tick();
        chk("n31_ret_clr", 64'(ret31), 64'd0);

        // 1: level line 3
        req = 16'h0008;
        #1;
        chk("t1_irq", 64'(irq), 64'd1);
        chk("t1_cause", 64'(cause), 64'h8000_0013);
        tick();
        req = '0;
        #1;
        chk("t1_busy_irq", 64'(irq), 64'd0);
        chk("t1_busy_cause", 64'(cause), 64'd0);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        chk("t1_ret", 64'(ret), 64'h0008);
        chk("t1_idle_irq", 64'(irq), 64'd0);
        tick();
        chk("t1_ret_clr", 64'(ret), 64'd0);

        // 2: lines 2 and 5 together
        req = 16'h0024;
        #1;
        chk("t2_irq", 64'(irq), 64'd1);
        chk("t2_cause2", 64'(cause), 64'h8000_0012);
        tick();
        req = 16'h0020;
        #1;
        chk("t2_busy_irq", 64'(irq), 64'd0);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        chk("t2_ret2", 64'(ret), 64'h0004);
        chk("t2_irq5", 64'(irq), 64'd1);
        chk("t2_cause5", 64'(cause), 64'h8000_0015);
        tick();
        req = '0;
        chk("t2_ret_clr", 64'(ret), 64'd0);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        chk("t2_ret5", 64'(ret), 64'h0020);
        tick();

        // 3: edge pulse on line 0 while serving line 4
        req = 16'h0010;
        #1;
        chk("t3_cause4", 64'(cause), 64'h8000_0014);
        tick();
        req = 16'h0001;
        #1;
        chk("t3_busy_irq", 64'(irq), 64'd0);
        tick();
        req = '0;
        #1;
        chk("t3_held_irq", 64'(irq), 64'd0);
        tick();
        mret = 1'b1;
        tick();
        mret = 1'b0;
        chk("t3_ret4", 64'(ret), 64'h0010);
        chk("t3_irq0", 64'(irq), 64'd1);
        chk("t3_cause0", 64'(cause), 64'h8000_0010);
        tick();
        chk("t3_busy0", 64'(irq), 64'd0);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        chk("t3_ret0", 64'(ret), 64'h0001);
        chk("t3_pend_clr", 64'(irq), 64'd0);
        tick();

        // 4: exception blocks the take for one cycle
        exc = 1'b1;
        req = 16'h0002;
        #1;
        chk("t4_exc_irq", 64'(irq), 64'd0);
        chk("t4_exc_cause", 64'(cause), 64'd0);
        tick();
        exc = 1'b0;
        #1;
        chk("t4_irq", 64'(irq), 64'd1);
        chk("t4_cause", 64'(cause), 64'h8000_0011);
        tick();
        req = '0;
        mret = 1'b1;
        tick();
        mret = 1'b0;
        chk("t4_ret", 64'(ret), 64'h0002);
        tick();

        // 5: stray mret, then mret+exception while busy
        mret = 1'b1;
        tick();
        mret = 1'b0;
        chk("t5_idle_mret", 64'(ret), 64'd0);
        req = 16'h0040;
        #1;
        chk("t5_irq", 64'(irq), 64'd1);
        tick();
        req = '0;
        mret = 1'b1;
        exc = 1'b1;
        tick();
        mret = 1'b0;
        exc = 1'b0;
        chk("t5_exc_mret_ret", 64'(ret), 64'd0);
        req = 16'h0040;
        #1;
        chk("t5_still_busy", 64'(irq), 64'd0);
        req = '0;
        mret = 1'b1;
        tick();
        mret = 1'b0;
        chk("t5_ret", 64'(ret), 64'h0040);
        tick();

        // 6: asynchronous reset mid-service
        req = 16'h0080;
        #1;
        chk("t6_irq", 64'(irq), 64'd1);
        tick();
        #3;
        rst = 1'b1;
        #1;
        chk("t6_rst_irq", 64'(irq), 64'd0);
        chk("t6_rst_cause", 64'(cause), 64'd0);
        chk("t6_rst_ret", 64'(ret), 64'd0);
        tick();
        rst = 1'b0;
        req = '0;
        mret = 1'b1;
        tick();
        mret = 1'b0;
        chk("t6_no_ret", 64'(ret), 64'd0);
        req = 16'h0080;
        #1;
        chk("t6_refire", 64'(irq), 64'd1);
        req = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
